// File: rtl/riscv_regfile_mp_pkg.sv
// Shared constants for the multi-port RV32 register file and its scoreboard.
// Optional build macro used by the top: RISCV_REGFILE_BYPASS_EN.
package riscv_regfile_mp_pkg;

    localparam bit                    RV32E    = 1'b0;
    localparam int                    XLEN_DEF = 32;
    localparam int                    NREG_DEF = RV32E ? 16 : 32;
    localparam int                    SB_CNT_W = 2;
    localparam logic [SB_CNT_W-1:0]   SB_MAX   = 2'd3;
    localparam int                    X0_ADDR  = 0;

endpackage

// File: rtl/riscv_regfile_sb.sv
// Pending-write scoreboard: one saturating counter per register, set from issue,
// released from writeback; refuses reservations on saturated counters.
module riscv_regfile_sb
    import riscv_regfile_mp_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    parameter  int NWR  = 1,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sb_set,
    input  logic [AW-1:0]       i_sb_addr,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR-1:0]      i_wr_rel,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    output logic                o_sb_stall,
    output logic [SB_CNT_W-1:0] o_cnt [NREG]
);

    logic [SB_CNT_W-1:0] cnt     [NREG];
    logic [SB_CNT_W-1:0] cnt_nxt [NREG];
    logic [SB_CNT_W-1:0] dec     [NREG];
    logic [NREG-1:0]     inc;
    logic [NREG-1:0]     uflow;
    logic                rel_underflow;

    // Increment is only granted below SB_MAX, so the sum never exceeds SB_MAX.
    function automatic logic [SB_CNT_W-1:0] next_cnt(input logic [SB_CNT_W-1:0] cur,
                                                      input logic                inc_i,
                                                      input logic [SB_CNT_W-1:0] dec_i);
        logic [SB_CNT_W:0] up;
        up = {1'b0, cur} + {{SB_CNT_W{1'b0}}, inc_i};
        if (up >= {1'b0, dec_i})
            next_cnt = SB_CNT_W'(up - {1'b0, dec_i});
        else
            next_cnt = '0;
    endfunction

    always_comb begin
        o_sb_stall = i_sb_set && (i_sb_addr != AW'(X0_ADDR)) && (cnt[i_sb_addr] == SB_MAX);
        for (int r = 0; r < NREG; r++) begin
            dec[r] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (i_wr_rel[j] && i_wr_en[j] && (i_wr_addr[j*AW +: AW] == AW'(r)) && (r != X0_ADDR))
                    dec[r] = dec[r] + SB_CNT_W'(1);
            end
            inc[r]     = i_sb_set && (i_sb_addr == AW'(r)) && (r != X0_ADDR) && (cnt[r] != SB_MAX);
            cnt_nxt[r] = next_cnt(cnt[r], inc[r], dec[r]);
            uflow[r]   = {1'b0, dec[r]} > ({1'b0, cnt[r]} + {{SB_CNT_W{1'b0}}, inc[r]});
        end
        rel_underflow = |uflow;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
        end
    end

    assign o_cnt = cnt;

    // A release with nothing outstanding points at an issue/writeback mismatch upstream.
    cover property (@(posedge i_clk) disable iff (i_rst) rel_underflow);

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-port RV32 integer register file with pending-write scoreboard.
// Define RISCV_REGFILE_BYPASS_EN for write-through reads and release-aware busy.
module riscv_regfile_mp
    import riscv_regfile_mp_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    parameter  int NWR  = 1,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic [NWR-1:0]      i_wr_rel,
    input  logic                i_sb_set,
    input  logic [AW-1:0]       i_sb_addr,
    output logic                o_sb_stall
);

    logic [XLEN-1:0]     regs   [NREG];
    logic [SB_CNT_W-1:0] sb_cnt [NREG];
    logic [AW-1:0]       rd_a   [NRD];
`ifdef RISCV_REGFILE_BYPASS_EN
    logic [SB_CNT_W-1:0] byp_rel [NRD];
`endif

    riscv_regfile_sb #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_sb_set   (i_sb_set),
        .i_sb_addr  (i_sb_addr),
        .i_wr_en    (i_wr_en),
        .i_wr_rel   (i_wr_rel),
        .i_wr_addr  (i_wr_addr),
        .o_sb_stall (o_sb_stall),
        .o_cnt      (sb_cnt)
    );

    // Ascending port order lets the highest-index writer win on address collisions.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] != AW'(X0_ADDR)))
                    regs[i_wr_addr[j*AW +: AW]] <= i_wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_a[k]                     = i_rd_addr[k*AW +: AW];
            o_rd_data[k*XLEN +: XLEN]   = regs[rd_a[k]];
            o_rd_busy[k]                = (sb_cnt[rd_a[k]] != '0);
`ifdef RISCV_REGFILE_BYPASS_EN
            byp_rel[k] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (!i_rst && i_wr_en[j] && (rd_a[k] != AW'(X0_ADDR)) &&
                    (i_wr_addr[j*AW +: AW] == rd_a[k])) begin
                    o_rd_data[k*XLEN +: XLEN] = i_wr_data[j*XLEN +: XLEN];
                    if (i_wr_rel[j]) byp_rel[k] = byp_rel[k] + SB_CNT_W'(1);
                end
            end
            o_rd_busy[k] = (sb_cnt[rd_a[k]] > byp_rel[k]);
`endif
        end
    end

endmodule
